// File: rtl/trng_fifo_if.sv
// trng_fifo_if: bundle of the signals between the TRNG word buffer and its
// neighbours (upstream shift register and the AXI4-Lite read logic).
//
// Handshake semantics, upstream side:
//   shift_valid is a level held by upstream while it owns an unacknowledged
//   word. shift_out is stable for that whole time. The buffer answers with a
//   one-cycle shift_ready pulse in the cycle after it captures the word.
//   shift_valid is ignored while shift_ready is high. Upstream may drop
//   shift_valid at the edge that ends the shift_ready cycle.
// Read side:
//   rd_en is honoured at an edge only when empty=0. rd_valid pulses for one
//   cycle with the word on rd_data. rd_data holds between reads.
//
// Modports:
//   master - the block's environment: drives shift_out, shift_valid, flush, rd_en.
//   slave  - the buffer itself: drives shift_ready, rd_data, rd_valid, empty,
//            full, level, ovf_cnt, health_alarm.
interface trng_fifo_if #(
  parameter int Dbw   = 32,
  parameter int DEPTH = 16
);
  localparam int LW = $clog2(DEPTH) + 1;

  logic [Dbw-1:0] shift_out;
  logic           shift_valid;
  logic           shift_ready;
  logic           flush;
  logic           rd_en;
  logic [Dbw-1:0] rd_data;
  logic           rd_valid;
  logic           empty;
  logic           full;
  logic [LW-1:0]  level;
  logic [15:0]    ovf_cnt;
  logic           health_alarm;

  modport master (
    output shift_out, shift_valid, flush, rd_en,
    input  shift_ready, rd_data, rd_valid, empty, full, level, ovf_cnt,
           health_alarm
  );

  modport slave (
    input  shift_out, shift_valid, flush, rd_en,
    output shift_ready, rd_data, rd_valid, empty, full, level, ovf_cnt,
           health_alarm
  );
endinterface

// File: rtl/trng_fifo.sv
// trng_fifo: word buffer downstream of the TRNG shift register.
// It captures assembled random words on a valid/ready handshake and stores
// them in a synchronous FIFO. It presents them through a registered read port.
// Words arriving while full are dropped and counted, so upstream never stalls.
//
// Ports:
//   clock - global clock
//   reset - synchronous, active-high reset
//   bus   - trng_fifo_if.slave (shift_out/valid/ready, flush, rd_en,
//           rd_data/rd_valid, empty, full, level, ovf_cnt, health_alarm)
//
// Optional feature: define TRNG_FIFO_HEALTH_EN to compile in a
// repetition-count health test on captured words. Without it,
// health_alarm is tied low.
module trng_fifo #(
  parameter int Dbw        = 32,
  parameter int DEPTH      = 16,
  parameter int RCT_CUTOFF = 4
) (
  input  logic         clock,
  input  logic         reset,
  trng_fifo_if.slave   bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  if ((DEPTH < 4) || (DEPTH > 256) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("trng_fifo: DEPTH must be a power of two in 4..256");
  end
  if ((RCT_CUTOFF < 2) || (RCT_CUTOFF > 255)) begin : g_bad_cutoff
    $error("trng_fifo: RCT_CUTOFF must be in 2..255");
  end

  logic [Dbw-1:0] mem [DEPTH];
  logic [AW-1:0]  wr_ptr, rd_ptr;
  logic [LW-1:0]  level_q, level_next;
  logic           full_q, empty_q;
  logic           shift_ready_q;
  logic [Dbw-1:0] rd_data_q;
  logic           rd_valid_q;
  logic [15:0]    ovf_q;

  logic capture, rd_fire, room, wr_fire, drop;
  logic trip, alarm_q;

  // A word is captured once per handshake: shift_ready high masks the still
  // asserted shift_valid, and flush defers the capture by one cycle.
  assign capture = bus.shift_valid && !shift_ready_q && !bus.flush;
  assign rd_fire = bus.rd_en && !empty_q && !bus.flush;
  // A full FIFO still has room when the same edge reads a word out.
  assign room    = !full_q || rd_fire;
  assign wr_fire = capture && !alarm_q && !trip && room;
  assign drop    = capture && !alarm_q && !trip && !room;

  always_comb begin
    level_next = level_q;
    if (bus.flush) begin
      level_next = '0;
    end else begin
      unique case ({wr_fire, rd_fire})
        2'b10:   level_next = level_q + LW'(1);
        2'b01:   level_next = level_q - LW'(1);
        default: level_next = level_q;
      endcase
    end
  end

  // Storage has no reset so it can map onto RAM.
  always_ff @(posedge clock) begin
    if (wr_fire) begin
      mem[wr_ptr] <= bus.shift_out;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      level_q       <= '0;
      full_q        <= 1'b0;
      empty_q       <= 1'b1;
      shift_ready_q <= 1'b0;
      rd_data_q     <= '0;
      rd_valid_q    <= 1'b0;
      ovf_q         <= '0;
    end else begin
      shift_ready_q <= capture;
      rd_valid_q    <= rd_fire;
      level_q       <= level_next;
      full_q        <= (level_next == LW'(DEPTH));
      empty_q       <= (level_next == '0);
      if (rd_fire) begin
        rd_data_q <= mem[rd_ptr];
      end
      if (bus.flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (wr_fire) wr_ptr <= wr_ptr + AW'(1);
        if (rd_fire) rd_ptr <= rd_ptr + AW'(1);
      end
      if (drop && (ovf_q != 16'hFFFF)) begin
        ovf_q <= ovf_q + 16'd1;
      end
    end
  end

`ifdef TRNG_FIFO_HEALTH_EN
  // Repetition-count test. rep_cnt==0 marks "no word seen since reset".
  logic [7:0]     rep_cnt, rep_next;
  logic [Dbw-1:0] prev_word;

  always_comb begin
    rep_next = 8'd1;
    if ((rep_cnt != 8'd0) && (bus.shift_out == prev_word)) begin
      rep_next = (rep_cnt == 8'hFF) ? rep_cnt : rep_cnt + 8'd1;
    end
  end

  assign trip = capture && !alarm_q && (rep_next >= 8'(RCT_CUTOFF));

  always_ff @(posedge clock) begin
    if (reset) begin
      rep_cnt   <= '0;
      prev_word <= '0;
      alarm_q   <= 1'b0;
    end else begin
      if (capture) begin
        rep_cnt   <= rep_next;
        prev_word <= bus.shift_out;
      end
      if (trip) alarm_q <= 1'b1;
    end
  end
`else
  assign trip    = 1'b0;
  assign alarm_q = 1'b0;
`endif

  assign bus.shift_ready  = shift_ready_q;
  assign bus.rd_data      = rd_data_q;
  assign bus.rd_valid     = rd_valid_q;
  assign bus.empty        = empty_q;
  assign bus.full         = full_q;
  assign bus.level        = level_q;
  assign bus.ovf_cnt      = ovf_q;
  assign bus.health_alarm = alarm_q;
endmodule

// File: doc/trng_fifo.md
# trng_fifo

Word buffer directly downstream of the TRNG shift register. It accepts assembled random words on a valid/ready handshake and stores them in a synchronous FIFO. It presents them to the AXI4-Lite read logic through a registered read port. Words that arrive while the buffer is full are dropped and counted, so the entropy path never stalls.

## Interface
- Dbw, 32: data word width (32 or 64); matches upstream assembled word.
- DEPTH, 16: FIFO depth in words; power of two, 4..256.
- RCT_CUTOFF, 4: repetition-count cutoff (used only with health test compiled in); 2..255.

- clock  in  1  global clock.
- reset  in  1  reset, synchronous, active-high.
- shift_out  in  Dbw  assembled random word from upstream.
- shift_valid  in  1  level; high while upstream holds an unacknowledged word.
- shift_ready  out  1  registered one-cycle acknowledge to upstream.
- flush  in  1  synchronous clear of FIFO contents.
- rd_en  in  1  read request.
- rd_data  out  Dbw  read word, registered.
- rd_valid  out  1  one-cycle pulse; rd_data valid this cycle.
- empty  out  1  no words stored.
- full  out  1  DEPTH words stored.
- level  out  $clog2(DEPTH)+1  stored word count.
- ovf_cnt  out  16  dropped-word counter; saturates at 16'hFFFF.
- health_alarm  out  1  sticky repetition-test failure.

## Operation
- Capture: at a rising edge with shift_valid=1, shift_ready=0 and flush=0, the block samples shift_out and drives shift_ready<=1 for exactly one cycle. While shift_ready=1, shift_valid is ignored; this prevents a double capture of the same word.
- Write decision for a captured word, in priority order:
  - health_alarm=1: discard; ovf_cnt unchanged.
  - Not full, or full with rd_en accepted in the same cycle: write at wr_ptr and increment wr_ptr mod DEPTH.
  - Otherwise: discard and increment ovf_cnt (saturating).
- Read: at an edge with rd_en=1 and empty=0, rd_data<=mem[rd_ptr], rd_valid<=1, and rd_ptr increments mod DEPTH. rd_en while empty is ignored: rd_valid=0 and rd_data holds its value.
- Simultaneous read and write: level unchanged. This also applies when full, where the write is accepted into the slot the read frees.
- Flush: wr_ptr, rd_ptr and level go to 0. rd_data, ovf_cnt and health_alarm are kept. Flush has priority over both capture and read in the same cycle; a pending shift_valid is captured on the next cycle.
- Pointers are $clog2(DEPTH) bits and wrap naturally. level is tracked separately. full = (level==DEPTH); empty = (level==0).

## Timing
- Values after reset: shift_ready=0, rd_data=0, rd_valid=0, empty=1, full=0, level=0, ovf_cnt=0, health_alarm=0; both pointers at 0.
- Capture-to-ack latency: shift_ready is high in the cycle after the edge that sees shift_valid high. Upstream drops shift_valid one edge later.
- Upstream's minimum spacing between en_sr pulses is 2 cycles; shift_out is stable from the cycle shift_valid rises until capture.
- Back-to-back upstream words: the earliest next capture is 2 edges after the previous capture.
- Write-to-read: a word written at edge N is readable (empty=0) in the cycle after N. Issuing rd_en at edge N+1 gives rd_valid in the cycle after N+1.
- level, full and empty are registered and update on the same edge as the pointer change.
- Reset mid-handshake: shift_ready is cleared immediately. Upstream is reset by the same reset.

## Configuration
- TRNG_FIFO_HEALTH_EN defined: repetition-count test on captured words.
  - Each captured word (written or not) is compared with the previous captured word.
  - Equal: rep_cnt increments, saturating at 255. Different: rep_cnt=1. The first word after reset sets rep_cnt=1.
  - When rep_cnt reaches RCT_CUTOFF, health_alarm<=1 on that edge and the triggering word is discarded.
  - The alarm is sticky until reset; flush does not clear it.
- TRNG_FIFO_HEALTH_EN undefined: no comparator and no rep_cnt; health_alarm is tied to 0.

## Test plan
- Reset, then 3 upstream words 0xA5A5A5A5, 0x12345678, 0xDEADBEEF, each acknowledged with a single shift_ready pulse -> level=3; three rd_en pulses return them in order with rd_valid pulses; then empty=1.
- Fill DEPTH=16 words, then offer 3 more with no reads -> full=1, all 3 acknowledged, ovf_cnt=3, FIFO contents unchanged.
- Full FIFO, rd_en and a capture on the same edge -> level stays 16, ovf_cnt unchanged, the new word is read last.
- rd_en while empty -> rd_valid=0 and rd_data holds its prior value. Flush with 5 stored words and shift_valid high -> level=0 next cycle; the pending word is captured one cycle later, giving level=1.
- With TRNG_FIFO_HEALTH_EN and RCT_CUTOFF=4, send 0x0 four times -> health_alarm=1 on the fourth capture, level=3, and later words are discarded with ovf_cnt unchanged.
- Reset asserted while shift_ready=1 and level=7 -> all outputs return to their reset values on the next edge.
